// File: rtl/mfp_uart_rx_oversampled.sv
// Oversampling 8N1 UART receiver feeding the UART program loader.
// Synchronises the raw line, rejects false starts, majority-votes three
// samples around each bit centre and reports framing errors.
//
// Ports:
//   HCLK           - system clock, rising edge
//   HRESETn        - asynchronous active-low reset
//   UART_RX        - asynchronous serial input, idle high
//   rx_data        - last correctly received byte
//   rx_valid       - one-cycle pulse, rx_data updated this cycle
//   rx_frame_error - one-cycle pulse, stop bit sampled low
//   rx_busy        - high from start-edge detection until back in IDLE
module mfp_uart_rx_oversampled #(
    parameter int unsigned CLOCK_FREQUENCY = 50000000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned OVERSAMPLE      = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       UART_RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_error,
    output logic       rx_busy
);

    localparam int unsigned DIV_RAW = CLOCK_FREQUENCY / (BAUD_RATE * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned SAMP_W  = $clog2(OVERSAMPLE);
    localparam int unsigned MID     = OVERSAMPLE / 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t              state_q, state_d;
    logic                rx_meta_q, rx_s_q;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [SAMP_W-1:0]   samp_cnt_q, samp_cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic                smp0_q, smp0_d;
    logic                smp1_q, smp1_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_ferr_q, rx_ferr_d;
    logic                rx_busy_q, rx_busy_d;

    logic                tick_c;
    logic                resolve_c;
    logic                vote_c;

    assign tick_c    = (tick_cnt_q == TICK_W'(DIV - 1));
    assign resolve_c = tick_c && (samp_cnt_q == SAMP_W'(MID + 1));
    // Third sample is the live synchronised line at resolution time.
    assign vote_c    = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);

    // Next-state, sampling and output logic.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        samp_cnt_d = samp_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        smp0_d     = smp0_q;
        smp1_d     = smp1_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;

        // Tick and sample counters only run while a frame is being sampled.
        if (state_q == START || state_q == DATA || state_q == STOP) begin
            tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
            if (tick_c) begin
                samp_cnt_d = (samp_cnt_q == SAMP_W'(OVERSAMPLE - 1)) ? '0
                                                                   : samp_cnt_q + SAMP_W'(1);
                if (samp_cnt_q == SAMP_W'(MID - 1)) smp0_d = rx_s_q;
                if (samp_cnt_q == SAMP_W'(MID))     smp1_d = rx_s_q;
            end
        end else begin
            tick_cnt_d = '0;
            samp_cnt_d = '0;
        end

        case (state_q)
            IDLE: begin
                bit_idx_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (resolve_c) begin
                    state_d   = vote_c ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (resolve_c) begin
                    shift_d   = {vote_c, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                // Return to IDLE at stop-bit centre so a back-to-back start is caught.
                if (resolve_c) begin
                    if (vote_c) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        rx_ferr_d  = 1'b1;
                        state_d    = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rx_busy_d = (state_d != IDLE);
    end

    // State and datapath registers; synchroniser resets to line idle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            samp_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            smp0_q     <= 1'b0;
            smp1_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            rx_meta_q  <= UART_RX;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            samp_cnt_q <= samp_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            smp0_q     <= smp0_d;
            smp1_q     <= smp1_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_busy_q  <= rx_busy_d;
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_frame_error = rx_ferr_q;
    assign rx_busy        = rx_busy_q;

endmodule

// File: tb/tb_mfp_uart_rx_oversampled.sv
// Bench for mfp_uart_rx_oversampled: directed frames plus random bytes,
// checked against a queue of expected bytes and expected event counts.
module tb_mfp_uart_rx_oversampled;

    localparam int unsigned CLK_F = 1600000;
    localparam int unsigned BAUD  = 10000;
    localparam int unsigned OS    = 16;
    localparam int          BIT   = 160;
    // Ideal start-edge to rx_valid distance: (9 + 9/16) bit times + 3 clocks.
    localparam int          LAT_NOM  = 9 * BIT + (9 * BIT) / 16 + 3;
    localparam int          BUSY_NOM = 9 * BIT + (9 * BIT) / 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_error;
    logic       rx_busy;

    int checks = 0;
    int errors = 0;

    int unsigned cyc = 0;
    int unsigned t_start = 0;
    int unsigned t_valid = 0;
    int          valid_cnt = 0;
    int          ferr_cnt = 0;
    int          busy_cycles = 0;
    logic        busy_seen = 1'b0;
    logic        prev_v = 1'b0;
    logic        prev_f = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_good = 8'h00;

    mfp_uart_rx_oversampled #(
        .CLOCK_FREQUENCY(CLK_F),
        .BAUD_RATE      (BAUD),
        .OVERSAMPLE     (OS)
    ) dut (
        .HCLK          (clk),
        .HRESETn       (rst_n),
        .UART_RX       (uart_rx),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_error(rx_frame_error),
        .rx_busy       (rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: compares every received byte against the expected queue.
    always @(negedge clk) begin
        if (rx_valid) begin
            t_valid = cyc;
            valid_cnt++;
            check("valid_1cyc", 32'(prev_v), 32'd0);
            if (exp_q.size() == 0) check("unexpected_valid", 32'd1, 32'd0);
            else                   check("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (rx_frame_error) begin
            ferr_cnt++;
            check("ferr_1cyc", 32'(prev_f), 32'd0);
        end
        if (rx_valid || rx_frame_error)
            check("pulse_excl", 32'(rx_valid & rx_frame_error), 32'd0);
        if (rx_busy) begin
            busy_cycles++;
            busy_seen = 1'b1;
        end
        prev_v = rx_valid;
        prev_f = rx_frame_error;
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            @(negedge clk);
            uart_rx = v;
        end
    endtask

    // One 8N1 frame; spike_bit >= 0 inserts a 10-clock inverted pulse at that bit's centre.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int spike_bit);
        t_start = cyc;
        drive(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                drive(b[i], 75);
                drive(~b[i], 10);
                drive(b[i], 75);
            end else begin
                drive(b[i], BIT);
            end
        end
        drive(stop_bit, BIT);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        last_good = b;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(rx_data), 32'd0);
        check({tag, "_valid"}, 32'(rx_valid), 32'd0);
        check({tag, "_ferr"},  32'(rx_frame_error), 32'd0);
        check({tag, "_busy"},  32'(rx_busy), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v0, f0, b0, exp_v, exp_f, n_bad;
        int unsigned lat;
        logic [7:0] rb;
        logic       good;
        logic [7:0] aborted;

        rst_n   = 1'b0;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        drive(1'b1, 2 * BIT);

        // Single frame 0x55: data, latency and busy length.
        v0 = valid_cnt; f0 = ferr_cnt; b0 = busy_cycles;
        expect_byte(8'h55);
        send_frame(8'h55, 1'b1, -1);
        drive(1'b1, BIT);
        check("b55_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("b55_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        lat = t_valid - t_start;
        check("b55_latency", 32'(lat + 20 >= LAT_NOM && lat <= LAT_NOM + 20), 32'd1);
        check("b55_busy_len", 32'(busy_cycles - b0 + 20 >= BUSY_NOM && busy_cycles - b0 <= BUSY_NOM + 20), 32'd1);
        check("b55_queue", 32'(exp_q.size()), 32'd0);

        // 40-clock low glitch: false start, back to idle inside the first bit time.
        v0 = valid_cnt; f0 = ferr_cnt;
        busy_seen = 1'b0;
        drive(1'b0, 40);
        drive(1'b1, BIT - 40);
        check("glitch_idle", 32'(rx_busy), 32'd0);
        check("glitch_busy_seen", 32'(busy_seen), 32'd1);
        drive(1'b1, BIT);
        check("glitch_valid", 32'(valid_cnt - v0), 32'd0);
        check("glitch_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Framing error followed by a 20-bit break, then a good byte.
        v0 = valid_cnt; f0 = ferr_cnt;
        send_frame(8'hA3, 1'b0, -1);
        drive(1'b0, 20 * BIT);
        check("ferr_busy_break", 32'(rx_busy), 32'd1);
        check("ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("ferr_data_kept", 32'(rx_data), 32'(last_good));
        drive(1'b1, 10);
        check("ferr_busy_release", 32'(rx_busy), 32'd0);
        drive(1'b1, BIT);
        expect_byte(8'h12);
        send_frame(8'h12, 1'b1, -1);
        drive(1'b1, BIT);
        check("b12_data", 32'(rx_data), 32'h12);
        check("b12_queue", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames with a single stop bit each.
        v0 = valid_cnt; f0 = ferr_cnt;
        expect_byte(8'h00); send_frame(8'h00, 1'b1, -1);
        expect_byte(8'hFF); send_frame(8'hFF, 1'b1, -1);
        expect_byte(8'h81); send_frame(8'h81, 1'b1, -1);
        drive(1'b1, BIT);
        check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd3);
        check("b2b_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        check("b2b_queue", 32'(exp_q.size()), 32'd0);

        // Single-sample spike in data bit 3 is outvoted.
        expect_byte(8'h00);
        send_frame(8'h00, 1'b1, 3);
        drive(1'b1, BIT);
        check("spike_data", 32'(rx_data), 32'h00);
        check("spike_queue", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 4, then a clean frame.
        v0 = valid_cnt; f0 = ferr_cnt;
        aborted = 8'hA5;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(aborted[i], BIT);
        drive(aborted[4], BIT / 2);
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (20) @(negedge clk);
        check("midrst_busy_hold", 32'(rx_busy), 32'd0);
        rst_n = 1'b1;
        last_good = 8'h00;
        drive(1'b1, 2 * BIT);
        check("midrst_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("midrst_no_ferr", 32'(ferr_cnt - f0), 32'd0);
        expect_byte(8'h3C);
        send_frame(8'h3C, 1'b1, -1);
        drive(1'b1, BIT);
        check("b3c_data", 32'(rx_data), 32'h3C);
        check("b3c_queue", 32'(exp_q.size()), 32'd0);

        // Random bytes, occasional bad stop bits, random inter-frame gaps.
        v0 = valid_cnt; f0 = ferr_cnt;
        exp_v = 0; n_bad = 0;
        for (int k = 0; k < 16; k++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            if (good) begin
                expect_byte(rb);
                exp_v++;
                send_frame(rb, 1'b1, -1);
                drive(1'b1, int'($urandom_range(0, 2)) * BIT);
            end else begin
                n_bad++;
                send_frame(rb, 1'b0, -1);
                drive(1'b0, int'($urandom_range(1, 3)) * BIT);
                drive(1'b1, BIT);
            end
        end
        drive(1'b1, BIT);
        exp_f = n_bad;
        check("rand_valid_cnt", 32'(valid_cnt - v0), 32'(exp_v));
        check("rand_ferr_cnt", 32'(ferr_cnt - f0), 32'(exp_f));
        check("rand_queue", 32'(exp_q.size()), 32'd0);
        check("rand_last_data", 32'(rx_data), 32'(last_good));
        check("rand_idle", 32'(rx_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mfp_uart_rx_oversampled.md
Name: mfp_uart_rx_oversampled

Overview:
Oversampling UART receiver that converts the raw boot/reset serial line into a byte stream with a one-cycle valid strobe. It is the stage upstream of the UART program loader, which turns received bytes into AHB-Lite writes. It provides input synchronisation, false-start rejection, 3-sample majority voting and framing-error reporting, so the loader sees only clean bytes.

Parameters:
CLOCK_FREQUENCY, 50000000, HCLK frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
OVERSAMPLE, 16, sample ticks per bit. Must be even and at least 8.

Ports:
HCLK  input  1  system clock; all logic is on the rising edge.
HRESETn  input  1  asynchronous active-low reset.
UART_RX  input  1  asynchronous serial input, idle high, 8N1 format.
rx_data  output  8  last correctly received byte.
rx_valid  output  1  one-cycle pulse: rx_data updated this cycle.
rx_frame_error  output  1  one-cycle pulse: stop bit sampled low.
rx_busy  output  1  high from start-edge detection until return to IDLE.

Behaviour:
- Reset is one clock and asynchronous active-low. HRESETn low forces: rx_data=0, rx_valid=0, rx_frame_error=0, rx_busy=0, state=IDLE, synchroniser flops=1, counters=0. This applies immediately, including mid-frame.
- Synchroniser: UART_RX passes through 2 flops; all logic uses the second flop (rx_s).
- Tick generator:
  - DIV = CLOCK_FREQUENCY/(BAUD_RATE*OVERSAMPLE), integer floor, clamped to a minimum of 1.
  - One-cycle tick every DIV clocks.
  - The counter is held at 0 in IDLE, so sampling phase is aligned to the start edge.
- Sample counter: counts ticks 0..OVERSAMPLE-1 within a bit and wraps to 0.
- Majority vote: at sample indices M-1, M and M+1, where M=OVERSAMPLE/2, rx_s is captured. Bit value = majority of the 3 samples, resolved at tick M+1.
- States:
  - IDLE: rx_busy=0. When rx_s=0 is seen, go to START. Tick and sample counters are cleared.
  - START: at vote resolution, bit=1 means false start: go to IDLE with no output pulse. Bit=0 means go to DATA, bit index 0.
  - DATA: 8 bits, LSB first, shifted into an internal shift register at each vote resolution. After bit index 7, go to STOP.
  - STOP:
    - Vote=1: rx_data <= shift register and rx_valid=1 in the cycle after resolution; then go to IDLE.
    - Vote=0: rx_frame_error=1 for one cycle, rx_data is unchanged and no rx_valid is issued; go to WAIT_HIGH.
  - WAIT_HIGH: rx_busy=1. Stay until rx_s=1, which covers break conditions. Then go to IDLE. No further pulses are generated while the line stays low.
- Early start: IDLE is re-entered at stop-bit mid-sample, not at the end of the stop bit. A start edge arriving during the second half of the stop bit is therefore accepted; back-to-back frames are supported.
- Latency: rx_valid rises ≈ (9 + (M+1)/OVERSAMPLE) bit times plus 3 clocks after the start edge.
- Pulse exclusivity: rx_valid and rx_frame_error are never high in the same cycle. Each is high for exactly one HCLK cycle per event.
- Line state outside a frame: activity on UART_RX while in DATA or STOP only matters at the vote samples.

Test Plan:
- Bench parameters: CLOCK_FREQUENCY=1600000, BAUD_RATE=10000, OVERSAMPLE=16, giving DIV=10 and 160 clocks/bit.
- Send 0x55 8N1 -> exactly one rx_valid pulse with rx_data=0x55, about 1530 clocks after the start edge. rx_busy is high in between and rx_frame_error stays 0.
- Low glitch of 40 clocks on an idle line -> rx_busy pulses, no rx_valid and no rx_frame_error; state returns to IDLE before bit-time 1.
- Send 0xA3 with stop bit=0, then hold the line low for 20 bit times -> one rx_frame_error pulse, rx_data keeps its prior value, no rx_valid, rx_busy stays high until the line goes high. Then send 0x12 -> rx_valid with 0x12.
- Back-to-back frames 0x00, 0xFF, 0x81 with a single stop bit each -> three rx_valid pulses in order with the correct data and no errors.
- Single 10-clock high spike at the centre of data bit 3 of 0x00 -> the majority vote rejects it and rx_data=0x00.
- HRESETn asserted during bit 4 of a frame, released, then send 0x3C -> all outputs 0 during reset, no pulse from the aborted frame, and 0x3C received correctly.
